ipg_rreq_gen: RTL and testbench

- Initiator side of the IPG read-request protocol.
- Accepts a read request (src, dst), builds a 56-bit request message and serializes it MSB-first into the variable-size IPG slots offered by the PCS transmit path. Output chunks use the same MSB-aligned chunk/length format the remote read-request processor consumes.
- Tracks outstanding requests against a credit limit. The credit is returned by a pulse from the read-response reassembler.

---
 rtl/ipg_pkg.sv | 13 +
 rtl/ipg_rreq_gen_if.sv | 24 ++
 rtl/ipg_chunk_ser.sv | 51 +++++
 rtl/ipg_rreq_gen.sv | 59 +++++
 tb/tb_ipg_rreq_gen.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ipg_pkg.sv
// ipg_pkg: shared IPG widths, block types and FSM state encoding
package ipg_pkg;
  localparam int HDR_WIDTH = 16;
  localparam int ADR_WIDTH = 40;
  localparam int DATA_WIDTH = 64;
  localparam int LEN_WIDTH = 6;
  localparam int OUT_WIDTH = 3;
  localparam logic [7:0] BLK_READ = 8'h1a;
  localparam logic [7:0] BLK_WRITE = 8'h1b;
  localparam logic [7:0] BLK_RRESP = 8'h1c;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;
endpackage

// File: rtl/ipg_rreq_gen_if.sv
// ipg_rreq_gen_if: request, IPG slot/chunk and credit signals of the read-request initiator
interface ipg_rreq_gen_if;
  import ipg_pkg::*;
  logic req_valid;
  logic req_ready;
  logic [ADR_WIDTH/2-1:0] req_src;
  logic [ADR_WIDTH/2-1:0] req_dst;
  logic tx_slot_valid;
  logic [LEN_WIDTH-1:0] tx_slot_len;
  logic [DATA_WIDTH-1:0] tx_ipg_data;
  logic [LEN_WIDTH-1:0] tx_len;
  logic tx_valid;
  logic rresp_done;
  logic [OUT_WIDTH-1:0] outstanding;
  logic req_err;
  modport master (
    output req_valid, req_src, req_dst, tx_slot_valid, tx_slot_len, rresp_done,
    input req_ready, tx_ipg_data, tx_len, tx_valid, outstanding, req_err
  );
  modport slave (
    input req_valid, req_src, req_dst, tx_slot_valid, tx_slot_len, rresp_done,
    output req_ready, tx_ipg_data, tx_len, tx_valid, outstanding, req_err
  );
endinterface

// File: rtl/ipg_chunk_ser.sv
// ipg_chunk_ser: MSB-first message shifter emitting min(slot, remaining) bits per slot
module ipg_chunk_ser #(
  parameter int MSG_W = 56,
  parameter int DW = 64,
  parameter int LW = 6,
  parameter int RW = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic [MSG_W-1:0] i_msg,
  input  logic i_en,
  input  logic i_slot_valid,
  input  logic [LW-1:0] i_slot_len,
  output logic [DW-1:0] o_data,
  output logic [LW-1:0] o_len,
  output logic o_valid,
  output logic o_last
);
  logic [MSG_W-1:0] r_sh;
  logic [RW-1:0] r_rem;
  logic w_take;
  logic [RW-1:0] w_n7;
  logic [MSG_W-1:0] w_mask;
  always_comb begin
    w_take = i_en && i_slot_valid && i_slot_len != '0 && r_rem != '0;
    w_n7 = (RW'(i_slot_len) < r_rem) ? RW'(i_slot_len) : r_rem;
    w_mask = ~({MSG_W{1'b1}} >> w_n7);
    o_last = w_take && w_n7 == r_rem;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh <= '0;
      r_rem <= '0;
      o_data <= '0;
      o_len <= '0;
      o_valid <= 1'b0;
    end else begin
      if (i_load) begin
        r_sh <= i_msg;
        r_rem <= RW'(MSG_W);
      end else if (w_take) begin
        r_sh <= r_sh << w_n7;
        r_rem <= r_rem - w_n7;
      end
      o_valid <= w_take;
      o_len <= w_take ? w_n7[LW-1:0] : '0;
      o_data <= w_take ? {r_sh & w_mask, {(DW-MSG_W){1'b0}}} : '0;
    end
  end
endmodule

// File: rtl/ipg_rreq_gen.sv
// ipg_rreq_gen: builds read-request messages, serializes them into IPG slots, tracks credits
module ipg_rreq_gen
  import ipg_pkg::*;
#(
  parameter int RD_LEN = 512,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic clk,
  input logic reset,
  ipg_rreq_gen_if.slave bus
);
  localparam int MSG_W = HDR_WIDTH + ADR_WIDTH;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  logic [0:0] r_state;
  logic [OW-1:0] r_out;
  logic r_ready;
  logic r_err;
  logic w_acc;
  logic w_load;
  logic w_last;
  logic [0:0] w_state_nx;
  logic [OW-1:0] w_out_nx;
  always_comb begin
    w_acc = bus.req_valid && r_ready && r_state == ST_IDLE;
    w_load = w_acc && bus.req_src != bus.req_dst;
    w_state_nx = (r_state == ST_IDLE) ? (w_load ? ST_SEND : ST_IDLE) : (w_last ? ST_IDLE : ST_SEND);
    w_out_nx = r_out + OW'(w_last) - OW'(bus.rresp_done && r_out != '0);
  end
  ipg_chunk_ser #(.MSG_W(MSG_W), .DW(DATA_WIDTH), .LW(LEN_WIDTH), .RW(LEN_WIDTH + 1)) u_ser (
    .clk(clk),
    .rst(reset),
    .i_load(w_load),
    .i_msg({HDR_WIDTH'(RD_LEN), bus.req_src, bus.req_dst}),
    .i_en(r_state == ST_SEND),
    .i_slot_valid(bus.tx_slot_valid),
    .i_slot_len(bus.tx_slot_len),
    .o_data(bus.tx_ipg_data),
    .o_len(bus.tx_len),
    .o_valid(bus.tx_valid),
    .o_last(w_last)
  );
  // ready is registered from next-state values so it is low in the cycle after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_out <= '0;
      r_ready <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_out <= w_out_nx;
      r_ready <= w_state_nx == ST_IDLE && w_out_nx < OW'(MAX_OUTSTANDING);
      r_err <= w_acc && bus.req_src == bus.req_dst;
    end
  end
  assign bus.req_ready = r_ready;
  assign bus.req_err = r_err;
  assign bus.outstanding = r_out;
endmodule

// File: tb/tb_ipg_rreq_gen.sv
// tb_ipg_rreq_gen: scoreboard bench for the IPG read-request initiator
module tb_ipg_rreq_gen;
  typedef struct packed {
    logic [5:0] len;
    logic [63:0] data;
  } chunk_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  chunk_t q[$];
  chunk_t e;
  int checks = 0;
  int errors = 0;
  logic [55:0] m_msg = '0;
  int m_rem = 0;
  int m_out = 0;
  always #5 clk = ~clk;
  ipg_rreq_gen_if bus();
  ipg_rreq_gen dut (.clk(clk), .reset(reset), .bus(bus));
  always @(negedge clk) begin
    if (!reset && bus.tx_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL chunk_unexpected: got len %0d data %h, no chunk expected", bus.tx_len, bus.tx_ipg_data);
      end else begin
        e = q.pop_front();
        if (bus.tx_len !== e.len || bus.tx_ipg_data !== e.data) begin
          errors++;
          $display("FAIL chunk: got len %0d data %h, expected len %0d data %h", bus.tx_len, bus.tx_ipg_data, e.len, e.data);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_req(input logic [19:0] s, input logic [19:0] d);
    int i = 0;
    while (bus.req_ready !== 1'b1 && i < 20) begin
      cyc();
      i++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_wait: got %b expected 1 within 20 cycles", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_src = s;
    bus.req_dst = d;
    cyc();
    bus.req_valid = 1'b0;
    if (s != d) begin
      m_msg = {16'h0200, s, d};
      m_rem = 56;
    end
  endtask
  task automatic offer(input logic v, input logic [5:0] l, input logic done);
    int n;
    logic [63:0] full;
    chunk_t c;
    bit dec;
    dec = done && m_out > 0;
    if (v && l != 0 && m_rem > 0) begin
      n = (int'(l) < m_rem) ? int'(l) : m_rem;
      full = {m_msg, 8'h00};
      c.len = 6'(n);
      c.data = full & ~(64'hFFFF_FFFF_FFFF_FFFF >> n);
      q.push_back(c);
      m_msg = m_msg << n;
      m_rem -= n;
      if (m_rem == 0) m_out++;
    end
    if (dec) m_out--;
    bus.tx_slot_valid = v;
    bus.tx_slot_len = l;
    bus.rresp_done = done;
    cyc();
    bus.tx_slot_valid = 1'b0;
    bus.tx_slot_len = '0;
    bus.rresp_done = 1'b0;
  endtask
  task automatic test_reset();
    repeat (3) cyc();
    checks++;
    if ({bus.tx_valid, bus.tx_len, bus.tx_ipg_data, bus.outstanding, bus.req_err, bus.req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid %b len %0d data %h out %0d err %b ready %b, expected all 0",
               bus.tx_valid, bus.tx_len, bus.tx_ipg_data, bus.outstanding, bus.req_err, bus.req_ready);
    end
    reset = 1'b0;
    cyc();
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 1", bus.req_ready);
    end
  endtask
  task automatic test_err();
    do_req(20'h00005, 20'h00005);
    checks++;
    if (bus.req_err !== 1'b1) begin
      errors++;
      $display("FAIL req_err_pulse: got %b expected 1", bus.req_err);
    end
    cyc();
    checks++;
    if ({bus.req_err, bus.req_ready, bus.tx_valid, bus.outstanding} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL req_err_after: got err %b ready %b valid %b out %0d, expected 0 1 0 0",
               bus.req_err, bus.req_ready, bus.tx_valid, bus.outstanding);
    end
  endtask
  task automatic test_single();
    do_req(20'h00001, 20'h00002);
    offer(1'b1, 6'd63, 1'b0);
    @(negedge clk);
    checks++;
    if ({bus.tx_valid, bus.tx_len, bus.tx_ipg_data} !== {1'b1, 6'd56, 56'h0200_0000_1000_02, 8'h00}) begin
      errors++;
      $display("FAIL single_chunk: got valid %b len %0d data %h, expected 1 56 %h",
               bus.tx_valid, bus.tx_len, bus.tx_ipg_data, {56'h0200_0000_1000_02, 8'h00});
    end
    checks++;
    if (bus.outstanding !== 3'd1) begin
      errors++;
      $display("FAIL single_outstanding: got %0d expected 1", bus.outstanding);
    end
    cyc();
  endtask
  task automatic test_split();
    do_req(20'h00001, 20'h00002);
    offer(1'b1, 6'd8, 1'b0);
    offer(1'b1, 6'd0, 1'b0);
    checks++;
    if ({bus.tx_valid, bus.tx_len, bus.tx_ipg_data} !== '0) begin
      errors++;
      $display("FAIL zero_slot: got valid %b len %0d data %h, expected all 0", bus.tx_valid, bus.tx_len, bus.tx_ipg_data);
    end
    offer(1'b1, 6'd20, 1'b0);
    offer(1'b1, 6'd40, 1'b0);
    cyc();
    checks++;
    if (bus.outstanding !== 3'd2 || q.size() != 0) begin
      errors++;
      $display("FAIL split_end: got out %0d pending %0d, expected 2 and 0", bus.outstanding, q.size());
    end
  endtask
  task automatic test_credit();
    do_req(20'h00003, 20'h00004);
    offer(1'b1, 6'd63, 1'b0);
    do_req(20'h00006, 20'h00007);
    offer(1'b1, 6'd63, 1'b0);
    cyc();
    checks++;
    if (bus.outstanding !== 3'd4 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL credit_full: got out %0d ready %b, expected 4 0", bus.outstanding, bus.req_ready);
    end
    offer(1'b0, 6'd0, 1'b1);
    checks++;
    if (bus.outstanding !== 3'd3 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL credit_return: got out %0d ready %b, expected 3 1", bus.outstanding, bus.req_ready);
    end
    do_req(20'h00008, 20'h00009);
    offer(1'b1, 6'd40, 1'b0);
    offer(1'b1, 6'd40, 1'b1);
    checks++;
    if (bus.outstanding !== 3'd3) begin
      errors++;
      $display("FAIL credit_simul: got %0d expected 3", bus.outstanding);
    end
    cyc();
  endtask
  task automatic test_mid_reset();
    do_req(20'h00001, 20'h00002);
    offer(1'b1, 6'd16, 1'b0);
    offer(1'b1, 6'd16, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    bus.tx_slot_valid = 1'b1;
    bus.tx_slot_len = 6'd16;
    cyc();
    m_rem = 0;
    m_out = 0;
    checks++;
    if ({bus.tx_valid, bus.tx_len, bus.tx_ipg_data, bus.outstanding, bus.req_err, bus.req_ready} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got valid %b len %0d data %h out %0d err %b ready %b, expected all 0",
               bus.tx_valid, bus.tx_len, bus.tx_ipg_data, bus.outstanding, bus.req_err, bus.req_ready);
    end
    reset = 1'b0;
    cyc();
    cyc();
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_slot: got tx_valid %b expected 0", bus.tx_valid);
    end
    bus.tx_slot_valid = 1'b0;
    bus.tx_slot_len = '0;
    do_req(20'hABCDE, 20'h12345);
    offer(1'b1, 6'd63, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.tx_ipg_data[63:48] !== 16'h0200) begin
      errors++;
      $display("FAIL restart_header: got %h expected 0200", bus.tx_ipg_data[63:48]);
    end
    cyc();
  endtask
  task automatic test_underflow();
    offer(1'b0, 6'd0, 1'b1);
    checks++;
    if (bus.outstanding !== 3'd0) begin
      errors++;
      $display("FAIL credit_to_zero: got %0d expected 0", bus.outstanding);
    end
    offer(1'b0, 6'd0, 1'b1);
    checks++;
    if (bus.outstanding !== 3'd0) begin
      errors++;
      $display("FAIL credit_underflow: got %0d expected 0", bus.outstanding);
    end
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_src = '0;
    bus.req_dst = '0;
    bus.tx_slot_valid = 1'b0;
    bus.tx_slot_len = '0;
    bus.rresp_done = 1'b0;
    test_reset();
    test_err();
    test_single();
    test_split();
    test_credit();
    test_mid_reset();
    test_underflow();
    cyc();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL chunks_missing: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
